pe_row_drain: RTL and testbench

PE_ROW_DRAIN -- requirements
Module: pe_row_drain

---
 rtl/pe_row_drain.sv | 180 ++++++++++++++++++
 tb/tb_pe_row_drain.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_row_drain.sv
// Collects one result per PE lane and drains them round-robin into a single
// valid/ready output stream, tagging each word with the node it belongs to.
module pe_row_drain #(
   parameter int PE_DIM       = 16,
   parameter int PE_OUT_WIDTH = 8,
   parameter int NODE_WIDTH   = 12,
   parameter int LOG_PE_DIM   = $clog2(PE_DIM)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [PE_OUT_WIDTH*PE_DIM-1:0]   sum_in_bus,
   input  logic [PE_DIM-1:0]                vd_in,
   input  logic                             node_adv,
   input  logic                             clr_ovf,
   output logic [PE_OUT_WIDTH-1:0]          out_data,
   output logic [LOG_PE_DIM-1:0]            out_lane,
   output logic [NODE_WIDTH-1:0]            out_node,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             busy,
   output logic                             ovf
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;

   logic [PE_DIM-1:0]       pending_q, pending_d;
   logic [PE_OUT_WIDTH-1:0] data_q [PE_DIM];
   logic [PE_OUT_WIDTH-1:0] data_d [PE_DIM];
   logic [NODE_WIDTH-1:0]   tag_q  [PE_DIM];
   logic [NODE_WIDTH-1:0]   tag_d  [PE_DIM];
   logic [NODE_WIDTH-1:0]   node_q, node_d;
   logic [LOG_PE_DIM-1:0]   ptr_q, ptr_d;
   logic                    ovf_q, ovf_d;
   logic [PE_OUT_WIDTH-1:0] out_data_q, out_data_d;
   logic [LOG_PE_DIM-1:0]   out_lane_q, out_lane_d;
   logic [NODE_WIDTH-1:0]   out_node_q, out_node_d;
   logic                    out_valid_q, out_valid_d;
   logic [1:0]              state_q, state_d;

   logic                    can_grant;
   logic                    grant_vld;
   logic [LOG_PE_DIM-1:0]   grant_idx;
   logic [LOG_PE_DIM-1:0]   scan_idx;
   logic [PE_DIM-1:0]       grant_oh;
   logic                    ovf_set;

   // Round-robin search starting at ptr_q; first pending lane found wins.
   always_comb begin
      can_grant = !out_valid_q || out_ready;
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int k = 0; k < PE_DIM; k++) begin
         scan_idx = LOG_PE_DIM'((int'(ptr_q) + k) % PE_DIM);
         if (!grant_vld && pending_q[scan_idx]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx;
         end
      end
      if (!can_grant) begin
         grant_vld = 1'b0;
      end
   end

   always_comb begin
      grant_oh = '0;
      for (int i = 0; i < PE_DIM; i++) begin
         grant_oh[i] = grant_vld && (grant_idx == LOG_PE_DIM'(i));
      end
   end

   // A lane being granted this cycle frees its slot, so a same-cycle capture refills it.
   always_comb begin
      pending_d = pending_q;
      data_d    = data_q;
      tag_d     = tag_q;
      ovf_set   = 1'b0;
      for (int i = 0; i < PE_DIM; i++) begin
         if (vd_in[i]) begin
            if (!pending_q[i] || grant_oh[i]) begin
               data_d[i]    = sum_in_bus[PE_OUT_WIDTH*i +: PE_OUT_WIDTH];
               tag_d[i]     = node_q;
               pending_d[i] = 1'b1;
            end else begin
               ovf_set = 1'b1;
            end
         end else if (grant_oh[i]) begin
            pending_d[i] = 1'b0;
         end
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_lane_d  = out_lane_q;
      out_node_d  = out_node_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (grant_vld) begin
         out_data_d  = data_q[grant_idx];
         out_lane_d  = grant_idx;
         out_node_d  = tag_q[grant_idx];
         out_valid_d = 1'b1;
         ptr_d       = (grant_idx == LOG_PE_DIM'(PE_DIM - 1)) ? '0
                                                              : grant_idx + LOG_PE_DIM'(1);
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      node_d = node_adv ? node_q + NODE_WIDTH'(1) : node_q;
      if (ovf_set) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_vld) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!out_valid_d)    state_d = ST_IDLE;
            else if (!out_ready) state_d = ST_STALL;
         end
         ST_STALL: begin
            if (out_ready) state_d = out_valid_d ? ST_DRAIN : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q   <= '0;
         node_q      <= '0;
         ptr_q       <= '0;
         ovf_q       <= 1'b0;
         out_data_q  <= '0;
         out_lane_q  <= '0;
         out_node_q  <= '0;
         out_valid_q <= 1'b0;
         state_q     <= ST_IDLE;
         for (int i = 0; i < PE_DIM; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         pending_q   <= pending_d;
         node_q      <= node_d;
         ptr_q       <= ptr_d;
         ovf_q       <= ovf_d;
         out_data_q  <= out_data_d;
         out_lane_q  <= out_lane_d;
         out_node_q  <= out_node_d;
         out_valid_q <= out_valid_d;
         state_q     <= state_d;
         for (int i = 0; i < PE_DIM; i++) begin
            data_q[i] <= data_d[i];
            tag_q[i]  <= tag_d[i];
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_lane  = out_lane_q;
   assign out_node  = out_node_q;
   assign out_valid = out_valid_q;
   assign ovf       = ovf_q;
   assign busy      = (|pending_q) || out_valid_q;

endmodule

// File: tb/tb_pe_row_drain.sv
// Scoreboard bench for pe_row_drain: tests push expected words, a negedge
// monitor pops and compares every accepted output word.
module tb_pe_row_drain;

   localparam int PE_DIM = 16;
   localparam int W      = 8;
   localparam int NW     = 12;
   localparam int LW     = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [W*PE_DIM-1:0] sum_in_bus;
   logic [PE_DIM-1:0] vd_in;
   logic              node_adv;
   logic              clr_ovf;
   logic [W-1:0]      out_data;
   logic [LW-1:0]     out_lane;
   logic [NW-1:0]     out_node;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              ovf;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [W+LW+NW-1:0] exp_q [$];
   logic [W+LW+NW-1:0] mon_exp;

   pe_row_drain #(
      .PE_DIM       (PE_DIM),
      .PE_OUT_WIDTH (W),
      .NODE_WIDTH   (NW),
      .LOG_PE_DIM   (LW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sum_in_bus (sum_in_bus),
      .vd_in      (vd_in),
      .node_adv   (node_adv),
      .clr_ovf    (clr_ovf),
      .out_data   (out_data),
      .out_lane   (out_lane),
      .out_node   (out_node),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
         total_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_word: got data=%h lane=%0d node=%0d, required no word",
                     out_data, out_lane, out_node);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({out_data, out_lane, out_node} !== mon_exp) begin
               $display("FAIL scoreboard: got data=%h lane=%0d node=%0d, required data=%h lane=%0d node=%0d",
                        out_data, out_lane, out_node, mon_exp[W+LW+NW-1 -: W],
                        mon_exp[LW+NW-1 -: LW], mon_exp[NW-1:0]);
            end else begin
               pass_cnt++;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] d, input logic [LW-1:0] l, input logic [NW-1:0] n);
      exp_q.push_back({d, l, n});
   endtask

   task automatic set_lane(input int i, input logic [W-1:0] v);
      sum_in_bus[W*i +: W] = v;
   endtask

   task automatic apply_reset();
      step();
      reset      = 1'b1;
      vd_in      = '0;
      sum_in_bus = '0;
      node_adv   = 1'b0;
      clr_ovf    = 1'b0;
      out_ready  = 1'b1;
      exp_q.delete();
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 300 && !ok; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && busy === 1'b0) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      total_cnt++;
      if ({out_valid, busy, ovf} !== 3'b000) begin
         $display("FAIL reset_flags: got valid/busy/ovf=%b, required 000", {out_valid, busy, ovf});
      end else pass_cnt++;
      total_cnt++;
      if ({out_data, out_lane, out_node} !== '0) begin
         $display("FAIL reset_outputs: got data=%h lane=%0d node=%0d, required 0/0/0",
                  out_data, out_lane, out_node);
      end else pass_cnt++;
   endtask

   task automatic test_single();
      apply_reset();
      set_lane(0, 8'h5A);
      vd_in = 16'h0001;
      push(8'h5A, 4'd0, 12'd0);
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL single_n: got out_valid=%b, required 0", out_valid);
      else pass_cnt++;
      step();
      vd_in = '0;
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL single_n1: got out_valid=%b, required 0", out_valid);
      else pass_cnt++;
      step();
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b1) $display("FAIL single_n2: got out_valid=%b, required 1", out_valid);
      else pass_cnt++;
      step();
      @(negedge clk);
      total_cnt++;
      if ({out_valid, busy} !== 2'b00) begin
         $display("FAIL single_idle: got valid/busy=%b, required 00", {out_valid, busy});
      end else pass_cnt++;
   endtask

   task automatic test_all_lanes();
      bit seen;
      apply_reset();
      for (int i = 0; i < PE_DIM; i++) begin
         set_lane(i, W'(i * 7 + 3));
         push(W'(i * 7 + 3), LW'(i), 12'd0);
      end
      vd_in = '1;
      step();
      vd_in = '0;
      seen = 1'b0;
      for (int c = 0; c < 6 && !seen; c++) begin
         @(negedge clk);
         seen = (out_valid === 1'b1);
      end
      total_cnt++;
      if (!seen) $display("FAIL all_first: got no out_valid within 6 cycles, required a word");
      else pass_cnt++;
      for (int k = 1; k < PE_DIM; k++) begin
         @(negedge clk);
         total_cnt++;
         if (out_valid !== 1'b1) $display("FAIL all_gap: got out_valid=0 at word %0d, required 1", k);
         else pass_cnt++;
      end
      @(negedge clk);
      total_cnt++;
      if ({out_valid, busy} !== 2'b00) begin
         $display("FAIL all_done: got valid/busy=%b, required 00", {out_valid, busy});
      end else pass_cnt++;
   endtask

   task automatic test_stall();
      bit seen;
      bit ok;
      apply_reset();
      out_ready = 1'b0;
      set_lane(2, 8'hA2);
      set_lane(5, 8'hB5);
      set_lane(9, 8'hC9);
      vd_in = 16'h0224;
      push(8'hA2, 4'd2, 12'd0);
      push(8'hB5, 4'd5, 12'd0);
      push(8'hC9, 4'd9, 12'd0);
      step();
      vd_in = '0;
      seen = 1'b0;
      for (int c = 0; c < 6 && !seen; c++) begin
         @(negedge clk);
         seen = (out_valid === 1'b1);
      end
      total_cnt++;
      if (!seen) $display("FAIL stall_first: got no out_valid within 6 cycles, required a word");
      else pass_cnt++;
      for (int k = 0; k < 5; k++) begin
         step();
         @(negedge clk);
         total_cnt++;
         if ({out_valid, out_data, out_lane} !== {1'b1, 8'hA2, 4'd2}) begin
            $display("FAIL stall_hold: got valid=%b data=%h lane=%0d, required 1/a2/2",
                     out_valid, out_data, out_lane);
         end else pass_cnt++;
      end
      step();
      out_ready = 1'b1;
      wait_idle(ok);
      total_cnt++;
      if (!ok) $display("FAIL stall_drain: got %0d words left, required 0", exp_q.size());
      else pass_cnt++;
   endtask

   task automatic test_overflow();
      bit ok;
      apply_reset();
      out_ready = 1'b0;
      set_lane(0, 8'h22);
      set_lane(3, 8'h11);
      vd_in = 16'h0009;
      push(8'h22, 4'd0, 12'd0);
      push(8'h11, 4'd3, 12'd0);
      step();
      vd_in = '0;
      step();
      step();
      set_lane(3, 8'h33);
      vd_in   = 16'h0008;
      clr_ovf = 1'b1;
      step();
      vd_in   = '0;
      clr_ovf = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (ovf !== 1'b1) $display("FAIL ovf_priority: got ovf=%b, required 1", ovf);
      else pass_cnt++;
      step();
      step();
      out_ready = 1'b1;
      wait_idle(ok);
      total_cnt++;
      if (!ok) $display("FAIL ovf_drain: got %0d words left, required 0", exp_q.size());
      else pass_cnt++;
      total_cnt++;
      if (ovf !== 1'b1) $display("FAIL ovf_sticky: got ovf=%b, required 1", ovf);
      else pass_cnt++;
      step();
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (ovf !== 1'b0) $display("FAIL ovf_clear: got ovf=%b, required 0", ovf);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      bit ok;
      apply_reset();
      set_lane(1, 8'h10);
      vd_in = 16'h0002;
      push(8'h10, 4'd1, 12'd0);
      step();
      set_lane(1, 8'h20);
      vd_in = 16'h0002;
      push(8'h20, 4'd1, 12'd0);
      step();
      vd_in = '0;
      wait_idle(ok);
      total_cnt++;
      if (!ok) $display("FAIL b2b_drain: got %0d words left, required 0", exp_q.size());
      else pass_cnt++;
      total_cnt++;
      if (ovf !== 1'b0) $display("FAIL b2b_ovf: got ovf=%b, required 0", ovf);
      else pass_cnt++;
   endtask

   task automatic test_tags();
      bit ok;
      apply_reset();
      node_adv = 1'b1;
      step();
      step();
      step();
      node_adv = 1'b0;
      set_lane(7, 8'h77);
      vd_in = 16'h0080;
      push(8'h77, 4'd7, 12'd3);
      step();
      vd_in = '0;
      wait_idle(ok);
      total_cnt++;
      if (!ok) $display("FAIL tag_three: got %0d words left, required 0", exp_q.size());
      else pass_cnt++;
      step();
      node_adv = 1'b1;
      repeat (4092) step();
      set_lane(2, 8'h42);
      vd_in = 16'h0004;
      push(8'h42, 4'd2, 12'd4095);
      step();
      node_adv = 1'b0;
      set_lane(4, 8'h44);
      vd_in = 16'h0010;
      push(8'h44, 4'd4, 12'd0);
      step();
      vd_in = '0;
      wait_idle(ok);
      total_cnt++;
      if (!ok) $display("FAIL tag_wrap: got %0d words left, required 0", exp_q.size());
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      bit clean;
      apply_reset();
      out_ready = 1'b0;
      vd_in = 16'h1152;
      step();
      vd_in = '0;
      step();
      step();
      @(negedge clk);
      total_cnt++;
      if ({busy, out_valid} !== 2'b11) begin
         $display("FAIL mid_busy: got busy/valid=%b, required 11", {busy, out_valid});
      end else pass_cnt++;
      step();
      reset     = 1'b1;
      out_ready = 1'b1;
      set_lane(0, 8'hEE);
      vd_in = 16'h0001;
      exp_q.delete();
      step();
      reset = 1'b0;
      vd_in = '0;
      @(negedge clk);
      total_cnt++;
      if ({out_valid, busy} !== 2'b00) begin
         $display("FAIL mid_cleared: got valid/busy=%b, required 00", {out_valid, busy});
      end else pass_cnt++;
      clean = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || busy !== 1'b0) clean = 1'b0;
      end
      total_cnt++;
      if (!clean) $display("FAIL mid_stale: got activity after reset, required none");
      else pass_cnt++;
   endtask

   initial begin
      reset      = 1'b1;
      sum_in_bus = '0;
      vd_in      = '0;
      node_adv   = 1'b0;
      clr_ovf    = 1'b0;
      out_ready  = 1'b1;
      test_reset();
      test_single();
      test_all_lanes();
      test_stall();
      test_overflow();
      test_back_to_back();
      test_tags();
      test_reset_mid();
      total_cnt++;
      if (exp_q.size() != 0) $display("FAIL leftover: got %0d queued words, required 0", exp_q.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
